mc_alu_b_ctrl: RTL and testbench

//  Multi-cycle control sequencer that drives the ALU-B operand select code (MUXT_ALU_B) and the
//  per-stage write enables. It is the producer side of the ALU-B select interface. It decodes
//  op/funct and steps IF->ID->EX->MEM->WB, with an EXC state for syscall/eret/illegal/bus-timeout.
//  It sits between the IR and the datapath muxes.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_instr_class.sv | 36 +++
 rtl/mc_alu_b_ctrl.sv | 159 +++++++++++++++
 tb/tb_mc_alu_b_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared encodings for the multi-cycle ALU-B control sequencer.
// Revision : 1.0
// ============================================================================
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_EXC = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_R    = 4'd1,
        CL_IALU = 4'd2,
        CL_LW   = 4'd3,
        CL_SW   = 4'd4,
        CL_BR   = 4'd5,
        CL_J    = 4'd6,
        CL_JAL  = 4'd7,
        CL_SYS  = 4'd8,
        CL_ERET = 4'd9,
        CL_ILL  = 4'd10
    } iclass_t;

    // ALU-B operand mux codes; 6 is unused by the datapath
    localparam logic [2:0] MUXT_ALU_B_4     = 3'd0;
    localparam logic [2:0] MUXT_ALU_B_RT    = 3'd1;
    localparam logic [2:0] MUXT_ALU_B_EXT16 = 3'd2;
    localparam logic [2:0] MUXT_ALU_B_EXT18 = 3'd3;
    localparam logic [2:0] MUXT_ALU_B_ZERO  = 3'd4;
    localparam logic [2:0] MUXT_ALU_B_CP0   = 3'd5;
    localparam logic [2:0] MUXT_ALU_B_NONE  = 3'd7;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [2:0] OP_IALU_HI = 3'b001;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ERET    = 6'b011000;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_instr_class.sv
`default_nettype none
// ============================================================================
// Module   : mc_instr_class
// Brief    : Combinational op/funct to instruction-class decoder.
// Revision : 1.0
// ============================================================================
module mc_instr_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    always_comb begin
        iclass = CL_ILL;
        if (op == OP_SPECIAL) begin
            iclass = (funct == FN_SYSCALL) ? CL_SYS : CL_R;
        end else if (op[5:3] == OP_IALU_HI) begin
            iclass = CL_IALU;
        end else begin
            case (op)
                OP_LW:   iclass = CL_LW;
                OP_SW:   iclass = CL_SW;
                OP_BEQ,
                OP_BNE:  iclass = CL_BR;
                OP_J:    iclass = CL_J;
                OP_JAL:  iclass = CL_JAL;
                OP_COP0: iclass = (funct == FN_ERET) ? CL_ERET : CL_ILL;
                default: iclass = CL_ILL;
            endcase
        end
    end

endmodule : mc_instr_class
`default_nettype wire

// File: rtl/mc_alu_b_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_b_ctrl
// Brief    : Multi-cycle IF/ID/EX/MEM/WB/EXC sequencer driving the ALU-B
//            operand select and per-stage write enables.
// Revision : 1.0
// ============================================================================
module mc_alu_b_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic [2:0] MUXT_ALU_B,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rf_we,
    output logic       dm_we,
    output logic       cp0_we,
    output logic       bus_err,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t           r_state;
    iclass_t          r_class;
    logic             r_op0;
    logic [CNT_W-1:0] r_cnt;

    iclass_t          w_class;
    logic             w_waiting;
    logic             w_timeout;

    mc_instr_class u_class (
        .op     (op),
        .funct  (funct),
        .iclass (w_class)
    );

    // Only IF and MEM wait on memory; a late mem_ready beats the timeout
    assign w_waiting = (r_state == ST_IF) || (r_state == ST_MEM);
    assign w_timeout = w_waiting && !mem_ready && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IF;
            r_class <= CL_NOP;
            r_op0   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IF: begin
                    if (mem_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_ID;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= ST_EXC;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_ID: begin
                    r_class <= w_class;
                    r_op0   <= op[0];
                    case (w_class)
                        CL_J:    r_state <= ST_IF;
                        CL_JAL:  r_state <= ST_WB;
                        CL_SYS,
                        CL_ERET,
                        CL_ILL:  r_state <= ST_EXC;
                        default: r_state <= ST_EX;
                    endcase
                end
                ST_EX: begin
                    case (r_class)
                        CL_BR:   r_state <= ST_IF;
                        CL_LW,
                        CL_SW:   r_state <= ST_MEM;
                        default: r_state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        r_cnt   <= '0;
                        r_state <= (r_class == CL_SW) ? ST_IF : ST_WB;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= ST_EXC;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_WB:   r_state <= ST_IF;
                ST_EXC:  r_state <= ST_IF;
                default: r_state <= ST_IF;
            endcase
        end
    end

    // ID decides jumps from the live decoder; later stages use the latched class
    always_comb begin
        MUXT_ALU_B = MUXT_ALU_B_NONE;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        dm_we      = 1'b0;
        cp0_we     = 1'b0;
        bus_err    = w_timeout;
        case (r_state)
            ST_IF: begin
                MUXT_ALU_B = MUXT_ALU_B_4;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
            end
            ST_ID: begin
                MUXT_ALU_B = MUXT_ALU_B_EXT18;
                pc_we      = (w_class == CL_J) || (w_class == CL_JAL);
            end
            ST_EX: begin
                case (r_class)
                    CL_R,
                    CL_BR:   MUXT_ALU_B = MUXT_ALU_B_RT;
                    CL_IALU,
                    CL_LW,
                    CL_SW:   MUXT_ALU_B = MUXT_ALU_B_EXT16;
                    default: MUXT_ALU_B = MUXT_ALU_B_NONE;
                endcase
                // op[0] distinguishes bne from beq
                pc_we = (r_class == CL_BR) && (alu_zero ^ r_op0);
            end
            ST_MEM: begin
                dm_we = (r_class == CL_SW);
            end
            ST_WB: begin
                rf_we = 1'b1;
            end
            ST_EXC: begin
                MUXT_ALU_B = MUXT_ALU_B_CP0;
                cp0_we     = 1'b1;
                pc_we      = 1'b1;
            end
            default: begin
                MUXT_ALU_B = MUXT_ALU_B_NONE;
            end
        endcase
    end

    assign state = r_state;

endmodule : mc_alu_b_ctrl
`default_nettype wire

// File: tb/tb_mc_alu_b_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_alu_b_ctrl
// Brief    : Self-checking bench; builds expected per-cycle traces from the
//            instruction class and memory wait pattern.
// Revision : 1.0
// ============================================================================
module tb_mc_alu_b_ctrl;

    localparam int MAX = 16;
    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_EXC = 3'd5;
    localparam int K_R = 0, K_IALU = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                   K_J = 5, K_JAL = 6, K_SYS = 7, K_ERET = 8, K_ILL = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] MUXT_ALU_B;
    logic       ir_we, pc_we, rf_we, dm_we, cp0_we, bus_err;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] mux;
        logic       ir, pc, rf, dm, cp0, be;
        logic       mr;
    } cyc_t;

    cyc_t q[$];
    logic [5:0] cur_op, cur_funct;
    logic       cur_az;

    mc_alu_b_ctrl #(.MEM_WAIT_MAX(MAX), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .MUXT_ALU_B (MUXT_ALU_B),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .dm_we      (dm_we),
        .cp0_we     (cp0_we),
        .bus_err    (bus_err),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        int v;
        v = int'(o);
        if (v == 0)             return (f == 6'd12) ? K_SYS : K_R;
        if (v >= 8 && v <= 15)  return K_IALU;
        if (v == 35)            return K_LW;
        if (v == 43)            return K_SW;
        if (v == 4 || v == 5)   return K_BR;
        if (v == 2)             return K_J;
        if (v == 3)             return K_JAL;
        if (v == 16 && f == 6'd24) return K_ERET;
        return K_ILL;
    endfunction

    function automatic cyc_t mk(input logic [2:0] st, input logic [2:0] mux,
                                input logic ir, input logic pc, input logic rf,
                                input logic dm, input logic cp0, input logic be,
                                input logic mr);
        cyc_t c;
        c.st = st; c.mux = mux; c.ir = ir; c.pc = pc; c.rf = rf;
        c.dm = dm; c.cp0 = cp0; c.be = be; c.mr = mr;
        return c;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Memory-wait phase: w low cycles then a ready cycle, unless MAX cycles run out first
    task automatic add_wait(input logic [2:0] st, input logic [2:0] mux, input logic dm,
                            input logic fetch, input int w, output bit tout);
        tout = 1'b0;
        for (int i = 0; i <= MAX; i++) begin
            if (i == w) begin
                q.push_back(mk(st, mux, fetch, fetch, 1'b0, dm, 1'b0, 1'b0, 1'b1));
                return;
            end
            if (i == MAX - 1) begin
                q.push_back(mk(st, mux, 1'b0, 1'b0, 1'b0, dm, 1'b0, 1'b1, 1'b0));
                tout = 1'b1;
                return;
            end
            q.push_back(mk(st, mux, 1'b0, 1'b0, 1'b0, dm, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic az,
                         input int if_wait, input int mem_wait);
        int  k;
        bit  t;
        cyc_t exc;
        q.delete();
        cur_op = o; cur_funct = f; cur_az = az;
        exc = mk(S_EXC, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, rbit());
        k = kind_of(o, f);
        add_wait(S_IF, 3'd0, 1'b0, 1'b1, if_wait, t);
        if (t) begin q.push_back(exc); return; end
        q.push_back(mk(S_ID, 3'd3, 1'b0, (k == K_J || k == K_JAL), 1'b0, 1'b0, 1'b0, 1'b0, rbit()));
        if (k == K_J) return;
        if (k == K_JAL) begin
            q.push_back(mk(S_WB, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rbit()));
            return;
        end
        if (k == K_SYS || k == K_ERET || k == K_ILL) begin q.push_back(exc); return; end
        q.push_back(mk(S_EX, (k == K_R || k == K_BR) ? 3'd1 : 3'd2, 1'b0,
                       (k == K_BR) && (az ^ o[0]), 1'b0, 1'b0, 1'b0, 1'b0, rbit()));
        if (k == K_BR) return;
        if (k == K_R || k == K_IALU) begin
            q.push_back(mk(S_WB, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rbit()));
            return;
        end
        add_wait(S_MEM, 3'd7, (k == K_SW), 1'b0, mem_wait, t);
        if (t) begin q.push_back(exc); return; end
        if (k == K_LW)
            q.push_back(mk(S_WB, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rbit()));
    endtask

    // Plays up to n cycles of the expected trace and compares every output each cycle
    task automatic run_trace(input string name, input int n);
        logic [11:0] act, expv;
        for (int i = 0; i < q.size() && i < n; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (i == 0) begin op = cur_op; funct = cur_funct; alu_zero = cur_az; end
            mem_ready = q[i].mr;
            #1;
            act  = {state, MUXT_ALU_B, ir_we, pc_we, rf_we, dm_we, cp0_we, bus_err};
            expv = {q[i].st, q[i].mux, q[i].ir, q[i].pc, q[i].rf, q[i].dm, q[i].cp0, q[i].be};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL %s cyc%0d: got st=%0d mux=%0d ir/pc/rf/dm/cp0/err=%06b, expected st=%0d mux=%0d ir/pc/rf/dm/cp0/err=%06b",
                         name, i, act[11:9], act[8:6], act[5:0], expv[11:9], expv[8:6], expv[5:0]);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = 1'b0;
            #1;
            checks++;
            if ({state, MUXT_ALU_B, ir_we, pc_we, rf_we, dm_we, cp0_we, bus_err} !== 12'h000) begin
                failures++;
                $display("FAIL reset: got st=%0d mux=%0d en=%06b, expected st=0 mux=0 en=000000",
                         state, MUXT_ALU_B, {ir_we, pc_we, rf_we, dm_we, cp0_we, bus_err});
            end
        end
    endtask

    task automatic test_add();
        build(6'd0, 6'b100000, 1'b0, 0, 0);
        run_trace("add", 100);
        build(6'd0, 6'b100000, 1'b1, 2, 0);
        run_trace("add_wait2", 100);
    endtask

    task automatic test_lw_wait();
        build(6'b100011, 6'd0, 1'b0, 0, 3);
        run_trace("lw_wait3", 100);
        build(6'b101011, 6'd0, 1'b0, 0, 2);
        run_trace("sw_wait2", 100);
    endtask

    task automatic test_branch();
        build(6'b000100, 6'd0, 1'b1, 0, 0);
        run_trace("beq_taken", 100);
        build(6'b000101, 6'd0, 1'b1, 0, 0);
        run_trace("bne_not_taken", 100);
        build(6'b000101, 6'd0, 1'b0, 0, 0);
        run_trace("bne_taken", 100);
        build(6'b000010, 6'd0, 1'b0, 0, 0);
        run_trace("j", 100);
        build(6'b000011, 6'd0, 1'b0, 0, 0);
        run_trace("jal", 100);
    endtask

    task automatic test_exc();
        build(6'b111111, 6'd0, 1'b0, 0, 0);
        run_trace("illegal", 100);
        build(6'd0, 6'b001100, 1'b0, 0, 0);
        run_trace("syscall", 100);
        build(6'b010000, 6'b011000, 1'b0, 0, 0);
        run_trace("eret", 100);
        build(6'b010000, 6'b000001, 1'b0, 0, 0);
        run_trace("cop0_bad_funct", 100);
    endtask

    task automatic test_timeout();
        build(6'd0, 6'b100000, 1'b0, 15, 0);
        run_trace("if_ready_last_cycle", 100);
        build(6'd0, 6'b100000, 1'b0, 40, 0);
        run_trace("if_timeout", 100);
        build(6'b100011, 6'd0, 1'b0, 0, 40);
        run_trace("mem_timeout", 100);
    endtask

    task automatic test_rst_mid_sw();
        build(6'b101011, 6'd0, 1'b0, 0, 10);
        run_trace("sw_pre_rst", 5);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (dm_we !== 1'b1 || state !== S_MEM) begin
            failures++;
            $display("FAIL sw_mem_before_rst: got st=%0d dm_we=%b, expected st=3 dm_we=1", state, dm_we);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== S_IF || dm_we !== 1'b0 || MUXT_ALU_B !== 3'd0 || pc_we !== 1'b0) begin
            failures++;
            $display("FAIL sw_after_rst: got st=%0d dm_we=%b mux=%0d pc_we=%b, expected st=0 dm_we=0 mux=0 pc_we=0",
                     state, dm_we, MUXT_ALU_B, pc_we);
        end
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        int w1, w2, sel;
        for (int n = 0; n < 60; n++) begin
            f   = 6'($urandom_range(0, 63));
            sel = $urandom_range(0, 11);
            case (sel)
                0:  o = 6'd0;
                1:  begin o = 6'd0; f = 6'b001100; end
                2:  o = 6'($urandom_range(8, 15));
                3:  o = 6'd35;
                4:  o = 6'd43;
                5:  o = 6'd4;
                6:  o = 6'd5;
                7:  o = 6'd2;
                8:  o = 6'd3;
                9:  begin o = 6'd16; f = ($urandom_range(0, 1) == 0) ? 6'd24 : f; end
                default: o = 6'($urandom_range(0, 63));
            endcase
            w1 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            w2 = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            build(o, f, rbit(), w1, w2);
            run_trace("random", 100);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_exc();
        test_timeout();
        test_rst_mid_sw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mc_alu_b_ctrl
`default_nettype wire
